// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI widths, response/burst encodings and master FSM state type
package axi_pkg;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ID_BITS    = 4;
   localparam int LEN_BITS   = 8;
   localparam int SIZE_BITS  = 3;
   localparam logic [2:0] RESP_OKAY   = 3'd0;
   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } axi_mst_state_e;
endpackage

// File: rtl/axi_interface_master.sv
// axi_interface_master: single-outstanding AXI4 master turning core burst requests into AXI transactions; optional watchdog under AXI_MASTER_TIMEOUT_EN
module axi_interface_master
   import axi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [LEN_BITS-1:0]     i_req_len,
   input  logic [SIZE_BITS-1:0]    i_req_size,
   input  logic [1:0]              i_req_burst,
   input  logic [ID_BITS-1:0]      i_req_id,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_rvalid,
   output logic                    o_rlast,
   input  logic                    i_rready,
   output logic                    o_done,
   output logic                    o_err,
   output logic [ID_BITS-1:0]      awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [LEN_BITS-1:0]     awlen,
   output logic [SIZE_BITS-1:0]    awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_BITS-1:0]      bid,
   input  logic [2:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_BITS-1:0]      arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [LEN_BITS-1:0]     arlen,
   output logic [1:0]              arburst,
   output logic [SIZE_BITS-1:0]    arsize,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_BITS-1:0]      rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [2:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);
   axi_mst_state_e        r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_BITS-1:0]   r_len, r_beat;
   logic [SIZE_BITS-1:0]  r_size;
   logic [1:0]            r_burst;
   logic [ID_BITS-1:0]    r_id;
   logic                  r_err;
   logic                  w_accept, w_last_beat, w_w_hs, w_r_hs;
   assign w_accept    = i_req_valid && (r_state == IDLE);
   assign w_last_beat = (r_beat == r_len);
   assign w_w_hs      = (r_state == WR_DATA) && i_wvalid && wready;
   assign w_r_hs      = (r_state == RD_DATA) && rvalid && i_rready;
   assign awid    = r_id;
   assign awaddr  = r_addr;
   assign awlen   = r_len;
   assign awsize  = r_size;
   assign awburst = r_burst;
   assign arid    = r_id;
   assign araddr  = r_addr;
   assign arlen   = r_len;
   assign arsize  = r_size;
   assign arburst = r_burst;
   assign wdata   = i_wdata;
   assign wstrb   = i_wstrb;
   assign o_rdata = rdata;
`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TO_W-1:0] r_to;
   logic            w_any_hs, w_to_hit;
   assign w_any_hs = ((r_state == WR_ADDR) && awready) || ((r_state == RD_ADDR) && arready) ||
                     w_w_hs || ((r_state == WR_RESP) && bvalid) || w_r_hs;
   assign w_to_hit = (r_state != IDLE) && (r_state != DONE) && (r_to == TO_W'(TIMEOUT_CYCLES - 1));
   // watchdog: counts stalled cycles in active states, restarting on any handshake or state change
   always_ff @(posedge clk_i) begin
      if (rst_i || w_any_hs || (w_next != r_state) || (r_state == IDLE) || (r_state == DONE)) r_to <= '0;
      else r_to <= r_to + 1'b1;
   end
`endif
   // state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // next-state decode; channel valids/readies exist only in their own phase
   always_comb begin
      w_next      = r_state;
      o_req_ready = 1'b0;
      awvalid     = 1'b0;
      arvalid     = 1'b0;
      wvalid      = 1'b0;
      wlast       = 1'b0;
      o_wready    = 1'b0;
      bready      = 1'b0;
      rready      = 1'b0;
      o_rvalid    = 1'b0;
      o_rlast     = 1'b0;
      o_done      = 1'b0;
      o_err       = 1'b0;
      case (r_state)
         IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) w_next = i_req_we ? WR_ADDR : RD_ADDR;
         end
         WR_ADDR: begin
            awvalid = 1'b1;
            if (awready) w_next = WR_DATA;
         end
         WR_DATA: begin
            wvalid   = i_wvalid;
            o_wready = wready;
            wlast    = w_last_beat;
            if (w_w_hs && w_last_beat) w_next = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next = DONE;
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) w_next = RD_DATA;
         end
         RD_DATA: begin
            rready   = i_rready;
            o_rvalid = rvalid;
            o_rlast  = rlast;
            if (w_r_hs && w_last_beat) w_next = DONE;
         end
         DONE: begin
            o_done = 1'b1;
            o_err  = r_err;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      if (w_to_hit) w_next = DONE;
`endif
   end
   // latch request attributes, count beats and accumulate the transaction error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_id    <= '0;
         r_beat  <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= i_req_addr;
            r_len   <= i_req_len;
            r_size  <= i_req_size;
            r_burst <= i_req_burst;
            r_id    <= i_req_id;
            r_beat  <= '0;
            r_err   <= 1'b0;
         end
         if (w_w_hs || w_r_hs) r_beat <= r_beat + 1'b1;
         if ((r_state == WR_RESP) && bvalid) r_err <= (bresp != RESP_OKAY) || (bid != r_id);
         if (w_r_hs) r_err <= r_err || (rresp != RESP_OKAY) || (rid != r_id) || (rlast != w_last_beat);
`ifdef AXI_MASTER_TIMEOUT_EN
         if (w_to_hit) r_err <= 1'b1;
`endif
         if (r_state == DONE) r_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_axi_interface_master.sv
// tb_axi_interface_master: directed bench with a transaction-level scoreboard for axi_interface_master
`timescale 1ns/1ps
module tb_axi_interface_master;
   import axi_pkg::*;
   logic clk_i = 1'b0, rst_i = 1'b1;
   logic i_req_valid, o_req_ready, i_req_we;
   logic [31:0] i_req_addr;
   logic [7:0] i_req_len;
   logic [2:0] i_req_size;
   logic [1:0] i_req_burst;
   logic [3:0] i_req_id;
   logic [31:0] i_wdata;
   logic [3:0] i_wstrb;
   logic i_wvalid, o_wready;
   logic [31:0] o_rdata;
   logic o_rvalid, o_rlast, i_rready, o_done, o_err;
   logic [3:0] awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0] awlen, arlen;
   logic [2:0] awsize, arsize, bresp, rresp;
   logic [1:0] awburst, arburst;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready;
   logic [3:0] wstrb;

   axi_interface_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
      .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_size(i_req_size),
      .i_req_burst(i_req_burst), .i_req_id(i_req_id),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_rlast(o_rlast), .i_rready(i_rready),
      .o_done(o_done), .o_err(o_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk_i = ~clk_i;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // transaction-level model
   typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;
   typedef struct packed {logic [31:0] d; logic l;} rbeat_t;
   wbeat_t exp_w[$];
   rbeat_t exp_r[$];
   bit     exp_done[$];
   logic [31:0] exp_addr;
   logic [7:0]  exp_len;
   logic [3:0]  exp_id;

   // slave knobs
   int aw_delay = 0, ar_delay = 0, rd_n = 0;
   logic wr_rdy = 1'b1;
   logic [2:0] b_resp = 3'd0;
   logic [3:0] b_id = 4'd0;
   logic [31:0] rd_data[16];
   logic        rd_last[16];
   logic [2:0]  rd_resp[16];
   logic [3:0]  rd_id[16];

   // core knobs
   int cw_n = 0, cw_idx = 0;
   logic [31:0] cw_data[16];
   logic [3:0]  cw_strb[16];
   bit rr_tog = 0;

   // observation counters
   int ar_cycles = 0, r_hs_cnt = 0;
   logic [31:0] last_rdata = '0;

   task automatic model_write(input int l);
      for (int i = 0; i <= l; i++) exp_w.push_back('{cw_data[i], cw_strb[i], i == l});
      exp_done.push_back((b_resp != RESP_OKAY) || (b_id != exp_id));
   endtask

   task automatic model_read(input int l);
      bit e = 0;
      for (int i = 0; i <= l; i++) begin
         exp_r.push_back('{rd_data[i], rd_last[i]});
         e = e || (rd_resp[i] != RESP_OKAY) || (rd_id[i] != exp_id) || (rd_last[i] != (i == l));
      end
      exp_done.push_back(e);
   endtask

   // AXI slave responder
   int aw_cnt = 0, ar_cnt = 0, ridx = 0;
   bit r_act = 0, s_ar_hs, s_r_hs;
   initial begin
      forever begin
         @(negedge clk_i);
         s_ar_hs = arvalid && arready;
         s_r_hs  = rvalid && rready;
         @(posedge clk_i); #1;
         if (rst_i) begin
            aw_cnt = 0; ar_cnt = 0; ridx = 0; r_act = 0;
         end else begin
            aw_cnt = awvalid ? aw_cnt + 1 : 0;
            ar_cnt = arvalid ? ar_cnt + 1 : 0;
            if (s_r_hs) ridx++;
            if (s_ar_hs) begin r_act = 1; ridx = 0; end
            if (ridx >= rd_n) r_act = 0;
         end
         awready = awvalid && (aw_cnt > aw_delay);
         arready = arvalid && (ar_cnt > ar_delay);
         wready  = wr_rdy;
         bvalid  = bready;
         bresp   = b_resp;
         bid     = b_id;
         rvalid  = r_act;
         rdata   = rd_data[ridx % 16];
         rlast   = rd_last[ridx % 16];
         rresp   = rd_resp[ridx % 16];
         rid     = rd_id[ridx % 16];
      end
   end

   // core-side write beat source and read consumer
   bit c_w_hs;
   initial begin
      forever begin
         @(negedge clk_i);
         c_w_hs = i_wvalid && o_wready;
         @(posedge clk_i); #1;
         if (c_w_hs) cw_idx++;
         i_wvalid = cw_idx < cw_n;
         i_wdata  = cw_data[cw_idx % 16];
         i_wstrb  = cw_strb[cw_idx % 16];
         i_rready = rr_tog ? ~i_rready : 1'b1;
      end
   end

   // scoreboard compare, every cycle out of reset
   wbeat_t wb;
   rbeat_t rb;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (awvalid) begin
            chk("awaddr", awaddr, exp_addr);
            chk("awlen", awlen, exp_len);
            chk("awid", awid, exp_id);
            chk("awsize", awsize, 3'd2);
            chk("awburst", awburst, BURST_INCR);
         end
         if (arvalid) begin
            ar_cycles++;
            chk("araddr", araddr, exp_addr);
            chk("arlen", arlen, exp_len);
            chk("arid", arid, exp_id);
            chk("arsize", arsize, 3'd2);
            chk("arburst", arburst, BURST_INCR);
         end
         if (wvalid && wready) begin
            if (exp_w.size() == 0) chk("w_unexpected_beat_count", 64'(exp_w.size() + 1), 64'd0);
            else begin
               wb = exp_w.pop_front();
               chk("wdata", wdata, wb.d);
               chk("wstrb", wstrb, wb.s);
               chk("wlast", wlast, wb.l);
            end
         end
         if (o_rvalid) chk("rready_mirror", rready, i_rready);
         if (o_rvalid && i_rready) begin
            r_hs_cnt++;
            last_rdata = o_rdata;
            if (exp_r.size() == 0) chk("r_unexpected_beat_count", 64'(exp_r.size() + 1), 64'd0);
            else begin
               rb = exp_r.pop_front();
               chk("o_rdata", o_rdata, rb.d);
               chk("o_rlast", o_rlast, rb.l);
            end
         end
         if (o_done) begin
            if (exp_done.size() == 0) chk("done_unexpected_count", 64'(exp_done.size() + 1), 64'd0);
            else chk("o_err", o_err, exp_done.pop_front());
         end
      end
   end

   task automatic start_req(input logic we, input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
      exp_addr = a; exp_len = l; exp_id = id;
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_len = l;
      i_req_size = 3'd2; i_req_burst = BURST_INCR; i_req_id = id;
      @(posedge clk_i); #3;
      i_req_valid = 1'b0;
   endtask

   task automatic wait_done(output logic err, input int budget);
      int n = 0;
      while (!o_done && n < budget) begin @(posedge clk_i); #3; n++; end
      total++;
      if (!o_done) begin bad++; $display("FAIL done_wait: o_done absent after %0d cycles", budget); end
      err = o_err;
      @(posedge clk_i); #3;
   endtask

   logic e;
   initial begin
      i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_len = 0; i_req_size = 0;
      i_req_burst = 0; i_req_id = 0; i_wdata = 0; i_wstrb = 0; i_wvalid = 0; i_rready = 1;
      for (int i = 0; i < 16; i++) begin
         cw_data[i] = 32'hA000_0000 + i; cw_strb[i] = 4'hF;
         rd_data[i] = 0; rd_last[i] = 0; rd_resp[i] = 0; rd_id[i] = 0;
      end
      repeat (3) @(posedge clk_i);
      #3;
      chk("rst_req_ready", o_req_ready, 1);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);
      chk("rst_done", o_done, 0);
      chk("rst_err", o_err, 0);
      chk("rst_wready", o_wready, 0);
      chk("rst_rvalid", o_rvalid, 0);
      rst_i = 0;
      @(posedge clk_i); #3;

      // write len 3, one extra core beat offered that must never be taken
      aw_delay = 0; b_resp = 0; b_id = 4'd5;
      cw_data[0] = 32'h1111_0000; cw_data[1] = 32'h2222_0001; cw_data[2] = 32'h3333_0002;
      cw_data[3] = 32'h4444_0003; cw_data[4] = 32'hDEAD_BEEF; cw_strb[2] = 4'h3;
      cw_idx = 0; cw_n = 5;
      exp_id = 4'd5;
      model_write(3);
      chk("t1_aw_before_accept", awvalid, 0);
      start_req(1, 32'h1000, 8'd3, 4'd5);
      chk("t1_aw_latency", awvalid, 1);
      wait_done(e, 50);
      chk("t1_err", e, 0);
      chk("t1_core_beats_taken", cw_idx, 4);
      chk("t1_w_left", exp_w.size(), 0);
      cw_n = 0;
      @(posedge clk_i); #3;

      // read len 0, arready three cycles late
      ar_delay = 3; rd_n = 1; rd_data[0] = 32'hCAFE_F00D; rd_last[0] = 1; rd_resp[0] = 0; rd_id[0] = 4'd3;
      exp_id = 4'd3; model_read(0); ar_cycles = 0;
      start_req(0, 32'h2000, 8'd0, 4'd3);
      wait_done(e, 50);
      chk("t2_err", e, 0);
      chk("t2_ar_hold_cycles", ar_cycles, 4);
      chk("t2_rdata", last_rdata, 32'hCAFE_F00D);

      // read len 7 with i_rready toggling
      ar_delay = 0; rd_n = 8; rr_tog = 1;
      for (int i = 0; i < 8; i++) begin
         rd_data[i] = 32'h100 + i; rd_last[i] = (i == 7); rd_resp[i] = 0; rd_id[i] = 4'd1;
      end
      exp_id = 4'd1; model_read(7); r_hs_cnt = 0;
      start_req(0, 32'h2400, 8'd7, 4'd1);
      wait_done(e, 80);
      rr_tog = 0;
      chk("t3_err", e, 0);
      chk("t3_beats", r_hs_cnt, 8);
      chk("t3_last_rdata", last_rdata, 32'h107);
      chk("t3_r_left", exp_r.size(), 0);

      // write with SLVERR
      b_resp = 3'd2; b_id = 4'd6; cw_idx = 0; cw_n = 2;
      exp_id = 4'd6; model_write(1);
      start_req(1, 32'h1800, 8'd1, 4'd6);
      wait_done(e, 50);
      chk("t4a_slverr", e, 1);
      cw_n = 0;
      @(posedge clk_i); #3;

      // write with mismatched bid
      b_resp = 3'd0; b_id = 4'd9; cw_idx = 0; cw_n = 1;
      exp_id = 4'd6; model_write(0);
      start_req(1, 32'h1900, 8'd0, 4'd6);
      wait_done(e, 50);
      chk("t4b_bid_err", e, 1);
      cw_n = 0;
      @(posedge clk_i); #3;

      // read len 3 with rlast on the second beat
      rd_n = 4;
      for (int i = 0; i < 4; i++) begin
         rd_data[i] = 32'h5500 + i; rd_last[i] = (i == 1); rd_resp[i] = 0; rd_id[i] = 4'd2;
      end
      exp_id = 4'd2; model_read(3); r_hs_cnt = 0;
      start_req(0, 32'h3000, 8'd3, 4'd2);
      wait_done(e, 50);
      chk("t4c_rlast_err", e, 1);
      chk("t4c_beats", r_hs_cnt, 4);

      // reset in the middle of a write burst
      b_resp = 0; b_id = 4'd2; cw_idx = 0; cw_n = 4;
      exp_id = 4'd2; model_write(3);
      start_req(1, 32'h4000, 8'd3, 4'd2);
      begin
         int n = 0;
         while (cw_idx < 2 && n < 50) begin @(posedge clk_i); #3; n++; end
         chk("t5_two_beats", cw_idx, 2);
      end
      rst_i = 1; cw_n = 0;
      @(posedge clk_i); #3;
      chk("t5_awvalid", awvalid, 0);
      chk("t5_wvalid", wvalid, 0);
      chk("t5_wready", o_wready, 0);
      chk("t5_bready", bready, 0);
      chk("t5_arvalid", arvalid, 0);
      chk("t5_done", o_done, 0);
      chk("t5_req_ready", o_req_ready, 1);
      rst_i = 0;
      exp_w.delete(); exp_done.delete();
      @(posedge clk_i); #3;
      b_id = 4'd7; cw_idx = 0; cw_n = 2;
      cw_data[0] = 32'h7777_0000; cw_data[1] = 32'h7777_0001;
      exp_id = 4'd7; model_write(1);
      start_req(1, 32'h5000, 8'd1, 4'd7);
      wait_done(e, 50);
      chk("t5_after_reset_err", e, 0);
      chk("t5_w_left", exp_w.size(), 0);
      cw_n = 0;
      @(posedge clk_i); #3;

`ifdef AXI_MASTER_TIMEOUT_EN
      // awready never arrives: watchdog ends the transaction after 16 cycles
      aw_delay = 1000;
      exp_done.push_back(1'b1);
      start_req(1, 32'h6000, 8'd0, 4'd4);
      begin
         int n = 0;
         while (awvalid && n < 100) begin @(posedge clk_i); #3; n++; end
         chk("to_aw_cycles", n, 16);
         chk("to_done", o_done, 1);
         chk("to_err", o_err, 1);
      end
      @(posedge clk_i); #3;
      aw_delay = 0;
`endif

      chk("done_left", exp_done.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/axi_interface_master.md
Name: axi_interface_master

Overview:
- AXI4 master port that turns simple core burst requests into AXI transactions. It is the initiator-side counterpart of the AXI slave interface.
- Sits between a requester (DMA, crypto engine, CPU bridge) and the interconnect.
- One outstanding transaction at a time.
- Write beats and read beats stream through without storage, apart from the handshake registers.

Parameters:
TIMEOUT_CYCLES, 1024, idle-cycle limit for the watchdog; used only when AXI_MASTER_TIMEOUT_EN is defined.

Ports:
clk_i  in  1  clock; all logic on its rising edge
rst_i  in  1  reset, synchronous, active-high
i_req_valid / o_req_ready  in/out  1/1  request handshake
i_req_we  in  1  1 = write burst, 0 = read burst
i_req_addr / i_req_len / i_req_size / i_req_burst / i_req_id  in  ADDR_WIDTH / LEN_BITS / SIZE_BITS / 2 / ID_BITS  burst attributes
i_wdata / i_wstrb / i_wvalid / o_wready  in/in/in/out  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write beat stream
o_rdata / o_rvalid / o_rlast / i_rready  out/out/out/in  DATA_WIDTH / 1 / 1 / 1  read beat stream
o_done / o_err  out  1/1  transaction-end pulse; o_err is valid with o_done
awid, awaddr, awlen, awsize, awburst, awvalid / awready  out / in  AXI AW channel, widths per define.sv
wdata, wstrb, wlast, wvalid / wready  out / in  AXI W channel
bid, bresp[2:0], bvalid / bready  in / out  AXI B channel
arid, araddr, arlen, arburst, arsize, arvalid / arready  out / in  AXI AR channel
rid, rdata, rresp[2:0], rlast, rvalid / rready  in / out  AXI R channel

Behaviour:
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- Reset values:
  - state = IDLE.
  - awvalid, arvalid, wvalid, bready, rready, o_done, o_err, o_wready, o_rvalid = 0.
  - o_req_ready = 1.
- Request acceptance:
  - o_req_ready = (state == IDLE).
  - On i_req_valid && o_req_ready, latch addr/len/size/burst/id/we.
  - Next state is WR_ADDR or RD_ADDR.
  - awvalid or arvalid is registered high in the next cycle, i.e. latency 1.
- Address phases (WR_ADDR / RD_ADDR):
  - AW/AR fields are driven from the latched registers and are stable while valid is high.
  - Valid is held until the ready handshake; it drops in the cycle after the handshake.
  - Transitions: WR_ADDR → WR_DATA, RD_ADDR → RD_DATA.
  - awready/arready already high on the first valid cycle means a single-cycle phase.
- WR_DATA:
  - wvalid = i_wvalid and o_wready = wready; wdata/wstrb pass through combinationally.
  - A beat counter (LEN_BITS wide, cleared on request accept) increments on each wvalid && wready.
  - wlast = (beat_cnt == len_q); len_q = 0 means wlast on the first beat.
  - After the wlast handshake: o_wready = 0, bready = 1, move to WR_RESP.
  - Core beats beyond len+1 are never accepted.
- WR_RESP:
  - On bvalid && bready: err = (bresp != RESP_OKAY) || (bid != id_q).
  - Then move to DONE.
- RD_DATA:
  - rready = i_rready; o_rvalid = rvalid; o_rdata = rdata; o_rlast = rlast.
  - The beat counter increments per handshake.
  - A sticky err sets on any of:
    - rresp != RESP_OKAY
    - rid != id_q
    - rlast on a beat other than beat len_q
    - no rlast on beat len_q
  - The beat-len_q handshake ends the burst: move to DONE whether or not rlast is set.
- DONE:
  - o_done = 1 and o_err = err for exactly one cycle.
  - Return to IDLE; err clears. The next request can be accepted the following cycle.
- Reset mid-operation:
  - All valid/ready outputs drop at the reset edge and the FSM returns to IDLE.
  - Any in-flight AXI transaction is abandoned; the interconnect shares the reset.
- AWLEN/ARLEN = i_req_len unmodified (beats − 1). No 4KB-boundary splitting; the requester guarantees it.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- Defined:
  - A counter (clog2(TIMEOUT_CYCLES)+1 bits) runs in every non-IDLE, non-DONE state.
  - It clears on any AXI handshake and on state change.
  - On reaching TIMEOUT_CYCLES: drop all valids/readies, go to DONE with o_err = 1.
- Undefined: no counter; the FSM waits indefinitely in any state.

Decomposition:
- From define.sv: ADDR_WIDTH, DATA_WIDTH, ID_BITS, LEN_BITS, SIZE_BITS, RESP_OKAY.
- Shared package axi_pkg:
  - state typedef axi_mst_state_e.
  - Burst encodings BURST_FIXED = 0, BURST_INCR = 1, BURST_WRAP = 2.
- No sub-module; the beat counter and timeout counter stay inline.

Test Plan:
- Write, len = 3, INCR, addr 0x1000, awready/wready always 1 → awvalid 1 cycle after accept; 4 W beats; wlast on beat 4 only; bresp OKAY → o_done pulse with o_err = 0.
- Read, len = 0, arready delayed 3 cycles, arvalid held with araddr stable → single R beat with rlast → o_rlast = 1, o_done with o_err = 0.
- Read, len = 7, i_rready toggling every cycle → 8 beats delivered in order, no beat lost or duplicated; rready mirrors i_rready.
- Write with bresp = SLVERR (2), and separately a read with rlast on beat 2 of a len = 3 burst → o_err = 1 with o_done.
- Reset asserted mid WR_DATA after 2 of 4 beats → next cycle all valids 0, o_req_ready = 1; a new request completes normally.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, awready held 0 → exactly 16 cycles after awvalid rises, awvalid = 0 and o_done with o_err = 1.
